// File: rtl/axi_wr_pkg.sv
// Shared types and elaboration-time helpers for the AXI line burst writer.
// Used by axi_line_burst_writer and axi_wr_addr_gen.
package axi_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int bytes_per_beat(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int awsize(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int bursts_per_line(input int line_beats, input int burst_len);
    return line_beats / burst_len;
  endfunction

  // Counter width that stays legal when only one value is needed.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Line base address register (stride advance / frame rewind) and per-burst
// address computation. burst_addr reflects the line address being loaded.
module axi_wr_addr_gen
  import axi_wr_pkg::*;
#(
  parameter int                        AXI4_DATA_WIDTH = 128,
  parameter int                        AXI_ADDR_WIDTH  = 32,
  parameter int                        BURST_LEN       = 16,
  parameter int                        IDX_W           = 5,
  parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = 32'h1000_0000,
  parameter int                        LINE_STRIDE     = 7680
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rewind,
  input  logic                      advance,
  input  logic [IDX_W-1:0]          burst_idx,
  output logic [AXI_ADDR_WIDTH-1:0] burst_addr
);

  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES =
    AXI_ADDR_WIDTH'(bytes_per_beat(AXI4_DATA_WIDTH) * BURST_LEN);
  localparam logic [AXI_ADDR_WIDTH-1:0] STRIDE = AXI_ADDR_WIDTH'(LINE_STRIDE);

  logic [AXI_ADDR_WIDTH-1:0] line_addr_q, line_addr_d;

  // NOTE: default assignment first so every path drives line_addr_d; no latch.
  always_comb begin
    line_addr_d = line_addr_q;
    if (rewind) begin
      line_addr_d = FRAME_BASE_ADDR;
    end else if (advance) begin
      line_addr_d = line_addr_q + STRIDE;
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr_q <= FRAME_BASE_ADDR;
    end else begin
      line_addr_q <= line_addr_d;
    end
  end

  assign burst_addr = line_addr_d + AXI_ADDR_WIDTH'(burst_idx) * BURST_BYTES;

endmodule

// File: rtl/axi_line_burst_writer.sv
// Drains a FWFT pixel FIFO into DDR as one AXI4 INCR burst train per video line.
// Optional macro AXI_WR_BRESP_CHECK_EN enables the sticky wr_err on non-OKAY BRESP.
module axi_line_burst_writer
  import axi_wr_pkg::*;
#(
  parameter int                        AXI4_DATA_WIDTH = 128,
  parameter int                        AXI_ADDR_WIDTH  = 32,
  parameter int                        BURST_LEN       = 16,
  parameter int                        LINE_BEATS      = 480,
  parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = 32'h1000_0000,
  parameter int                        LINE_STRIDE     = 7680
) (
  input  logic                         M_AXI_ACLK,
  input  logic                         M_AXI_ARESET,
  input  logic                         frame_start,
  input  logic                         AXI_FULL_BURST_VALID,
  output logic                         AXI_FULL_BURST_READY,
  input  logic [AXI4_DATA_WIDTH-1:0]   fifo_rd_data,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  output logic [AXI_ADDR_WIDTH-1:0]    M_AXI_AWADDR,
  output logic [7:0]                   M_AXI_AWLEN,
  output logic [2:0]                   M_AXI_AWSIZE,
  output logic [1:0]                   M_AXI_AWBURST,
  output logic                         M_AXI_AWVALID,
  input  logic                         M_AXI_AWREADY,
  output logic [AXI4_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [AXI4_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                         M_AXI_WLAST,
  output logic                         M_AXI_WVALID,
  input  logic                         M_AXI_WREADY,
  input  logic [1:0]                   M_AXI_BRESP,
  input  logic                         M_AXI_BVALID,
  output logic                         M_AXI_BREADY,
  output logic                         busy,
  output logic                         wr_err
);

  localparam int BPL         = bursts_per_line(LINE_BEATS, BURST_LEN);
  localparam int IDX_W       = idx_width(BPL);
  localparam int CNT_W       = idx_width(BURST_LEN);
  localparam int BURST_BYTES = bytes_per_beat(AXI4_DATA_WIDTH) * BURST_LEN;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BPL - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  if ((LINE_BEATS % BURST_LEN) != 0) begin : g_bad_line
    $error("LINE_BEATS must be a multiple of BURST_LEN");
  end
  if ((4096 % BURST_BYTES) != 0) begin : g_bad_burst
    $error("burst byte count must divide 4096");
  end
  if ((FRAME_BASE_ADDR % BURST_BYTES) != 0 || (LINE_STRIDE % BURST_BYTES) != 0) begin : g_bad_align
    $error("FRAME_BASE_ADDR and LINE_STRIDE must be burst aligned");
  end

  wr_state_e                 state_q, state_d;
  logic [IDX_W-1:0]          burst_idx_q, burst_idx_d;
  logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic                      pend_rewind_q, pend_rewind_d;
  logic                      ready_q, ready_d;
  logic                      awvalid_q, awvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                      wlast_q, wlast_d;
  logic                      bready_q, bready_d;
  logic                      busy_q, busy_d;
  logic                      rewind, advance, w_hs;
  logic [AXI_ADDR_WIDTH-1:0] next_burst_addr;

  axi_wr_addr_gen #(
    .AXI4_DATA_WIDTH (AXI4_DATA_WIDTH),
    .AXI_ADDR_WIDTH  (AXI_ADDR_WIDTH),
    .BURST_LEN       (BURST_LEN),
    .IDX_W           (IDX_W),
    .FRAME_BASE_ADDR (FRAME_BASE_ADDR),
    .LINE_STRIDE     (LINE_STRIDE)
  ) u_addr_gen (
    .clk        (M_AXI_ACLK),
    .rst        (M_AXI_ARESET),
    .rewind     (rewind),
    .advance    (advance),
    .burst_idx  (burst_idx_d),
    .burst_addr (next_burst_addr)
  );

  assign M_AXI_WVALID = (state_q == ST_W) && !fifo_empty;
  assign w_hs         = M_AXI_WVALID && M_AXI_WREADY;

  always_comb begin
    state_d       = state_q;
    burst_idx_d   = burst_idx_q;
    beat_cnt_d    = beat_cnt_q;
    pend_rewind_d = pend_rewind_q || (frame_start && state_q != ST_IDLE);
    rewind        = 1'b0;
    advance       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rewind = frame_start;
        if (AXI_FULL_BURST_VALID && ready_q) begin
          state_d     = ST_AW;
          burst_idx_d = '0;
        end
      end
      ST_AW: begin
        if (M_AXI_AWREADY) begin
          state_d    = ST_W;
          beat_cnt_d = '0;
        end
      end
      ST_W: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (wlast_q) state_d = ST_B;
        end
      end
      ST_B: begin
        if (M_AXI_BVALID) begin
          if (burst_idx_q != LAST_IDX) begin
            burst_idx_d = burst_idx_q + IDX_W'(1);
            state_d     = ST_AW;
          end else begin
            // A frame_start seen during the line wins over the stride step.
            state_d       = ST_IDLE;
            rewind        = pend_rewind_q || frame_start;
            advance       = !(pend_rewind_q || frame_start);
            pend_rewind_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Control outputs are registered from the next state.
    ready_d   = (state_d == ST_IDLE);
    awvalid_d = (state_d == ST_AW);
    bready_d  = (state_d == ST_B);
    busy_d    = (state_d != ST_IDLE);
    wlast_d   = (state_d == ST_W) && (beat_cnt_d == LAST_BEAT);
    awaddr_d  = awaddr_q;
    if (state_d == ST_AW && state_q != ST_AW) awaddr_d = next_burst_addr;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q       <= ST_IDLE;
      burst_idx_q   <= '0;
      beat_cnt_q    <= '0;
      pend_rewind_q <= 1'b0;
      ready_q       <= 1'b0;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      wlast_q       <= 1'b0;
      bready_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      burst_idx_q   <= burst_idx_d;
      beat_cnt_q    <= beat_cnt_d;
      pend_rewind_q <= pend_rewind_d;
      ready_q       <= ready_d;
      awvalid_q     <= awvalid_d;
      awaddr_q      <= awaddr_d;
      wlast_q       <= wlast_d;
      bready_q      <= bready_d;
      busy_q        <= busy_d;
    end
  end

  assign AXI_FULL_BURST_READY = ready_q;
  assign M_AXI_AWVALID        = awvalid_q;
  assign M_AXI_AWADDR         = awaddr_q;
  assign M_AXI_AWLEN          = 8'(BURST_LEN - 1);
  assign M_AXI_AWSIZE         = 3'(awsize(AXI4_DATA_WIDTH));
  assign M_AXI_AWBURST        = AXI_BURST_INCR;
  assign M_AXI_WDATA          = fifo_rd_data;
  assign M_AXI_WSTRB          = '1;
  assign M_AXI_WLAST          = wlast_q;
  assign fifo_rd_en           = w_hs;
  assign M_AXI_BREADY         = bready_q;
  assign busy                 = busy_q;

`ifdef AXI_WR_BRESP_CHECK_EN
  logic wr_err_q, wr_err_d;

  always_comb begin
    wr_err_d = wr_err_q || (bready_q && M_AXI_BVALID && (M_AXI_BRESP != AXI_RESP_OKAY));
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^M_AXI_BRESP;
  assign wr_err       = 1'b0;
`endif

endmodule
